tx_stream_scheduler: RTL and testbench
======================================

# tx_stream_scheduler

Transmit-side scheduler that shares the Bluetooth UART transmitter between up to eight sensor-stream FIFOs. It sits beside `receiver_centre` and consumes that block's `stream_select` mask and `are_we_sending` flag. When sending is enabled and the Bluetooth link is up, it round-robins over the enabled, non-empty stream FIFOs. Each 16-bit word it pops goes out as a 3-byte packet (header, high byte, low byte) through a start/ready handshake with the UART transmitter.

## Interface
- No parameters. Fixed: 8 streams, 16-bit words, header byte = 8'hA0 | stream index.
- `clock` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low; sampled on the rising edge of `clock`.
- `bt_state` in 1: Bluetooth link connected (1 = connected).
- `are_we_sending` in 1: host enable for streaming, from `receiver_centre`.
- `stream_select` in 8: per-stream enable mask, from `receiver_centre`.
- `fifo_empty` in 8: per-stream FIFO empty flags.
- `fifo_data` in 128: stream i occupies bits [16i+15:16i]; valid the cycle after that stream's `fifo_rd_en`.
- `fifo_rd_en` out 8: one-hot, single-cycle pop strobe.
- `uart_ready` in 1: transmitter idle; the transmitter drops it the cycle after accepting `uart_start`.
- `uart_start` out 1: single-cycle strobe that launches `uart_data`.
- `uart_data` out 8: byte to transmit; held stable from `uart_start` until the transmitter raises `uart_ready` again.
- `current_stream` out 3: index of the last granted stream.
- `busy` out 1: high in every state except IDLE.
- `packets_sent` out 16: count of completed packets; wraps from 16'hFFFF to 0.

## Operation
- Eligibility: `elig[i] = stream_select[i] & ~fifo_empty[i]`.
- Run condition: `go = are_we_sending & bt_state`.
- States: IDLE, ARB, POP, LATCH, HDR, HDR_W, HI, HI_W, LO, LO_W.
- IDLE → ARB when `go`.
- ARB:
  - If `!go`, go to IDLE.
  - Else if `elig` is nonzero, grant the first eligible index searching `current_stream+1`, `+2`, … wrapping modulo 8. Load `current_stream`, then go to POP.
  - Else stay in ARB.
- POP: `fifo_rd_en[current_stream]` = 1 for exactly this cycle, then go to LATCH.
- LATCH: capture `fifo_data[current_stream]` into the word register, then go to HDR.
- HDR / HI / LO:
  - Drive `uart_data` with the header, word[15:8] or word[7:0] respectively.
  - Pulse `uart_start` in the first cycle `uart_ready` = 1, then go to the matching _W state.
  - While `uart_ready` = 0, wait with `uart_start` = 0.
- HDR_W / HI_W / LO_W:
  - Wait for `uart_ready` = 1. HDR_W then goes to HI, HI_W to LO.
  - LO_W increments `packets_sent` and goes to ARB.
- Packets are atomic. Dropping `go`, clearing a `stream_select` bit, or a FIFO going empty after POP never truncates a packet in flight; the condition takes effect at the next ARB.
- Fairness: with k streams continuously eligible, each is granted exactly once every k packets.
- `fifo_rd_en` is never asserted for a stream with `fifo_empty` = 1 at the ARB decision, nor for a stream with `stream_select` = 0 at that decision.

## Timing
- Reset values:
  - state = IDLE
  - `fifo_rd_en` = 0, `uart_start` = 0, `uart_data` = 0
  - `current_stream` = 3'd7, so stream 0 is searched first
  - `busy` = 0, `packets_sent` = 0
- Reset mid-packet: a reset in any state returns to IDLE on the next edge. The packet is abandoned and no further strobes are issued.
- All outputs are registered.
- Latency with `uart_ready` held high: ARB decision at cycle n, `fifo_rd_en` at n+1, LATCH at n+2, header `uart_start` at n+3.
- Byte spacing: the next `uart_start` comes no earlier than 1 cycle after `uart_ready` returns high.
- Minimum gap between consecutive `uart_start` pulses is 2 cycles. Two back-to-back pulses never occur.
- `uart_data` changes only on the cycle `uart_start` is asserted.

## Test plan
- Single stream: reset low for 5 cycles, then `go` = 1, `stream_select` = 8'h04, stream 2 holding 16'hBEEF. Model the transmitter as ready, busy for 10 cycles after each start. Required: bytes A2, BE, EF, `packets_sent` = 1, then the block sits in ARB with `busy` = 1.
- Round-robin: `stream_select` = 8'h29, streams 0, 3 and 5 each holding 2 words. Required grant order: 0, 3, 5, 0, 3, 5; headers A0, A3, A5, A0, A3, A5; `packets_sent` = 6.
- Gating: drop `bt_state` while in HI_W. Required: LO byte still sent, then IDLE, `busy` = 0, no further `fifo_rd_en` while `bt_state` = 0.
- Masking and empty: `stream_select` = 8'hFF with only stream 6 non-empty. Required: `fifo_rd_en` only ever 8'h40. Clearing bit 6 during POP still completes that packet, and the block then waits in ARB.
- Reset mid-operation: assert reset in HI. Required on the next edge: all outputs at reset values and `packets_sent` = 0. The counter wraps from 16'hFFFF to 0 (preloaded via force).

Source files
------------

// File: rtl/tx_stream_scheduler_if.sv
// Scheduler-facing bundle: stream FIFO pop port and UART transmitter start/ready port.
// master = scheduler side, slave = FIFO bank / transmitter side.
interface tx_stream_scheduler_if;
  logic [7:0]   fifo_empty;
  logic [127:0] fifo_data;
  logic [7:0]   fifo_rd_en;
  logic         uart_ready;
  logic         uart_start;
  logic [7:0]   uart_data;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  uart_ready,
    output fifo_rd_en,
    output uart_start,
    output uart_data
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output uart_ready,
    input  fifo_rd_en,
    input  uart_start,
    input  uart_data
  );
endinterface

// File: rtl/tx_stream_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between eight 16-bit sensor streams.
// Each popped word leaves as an atomic 3-byte packet: header (A0|stream), high byte, low byte.
module tx_stream_scheduler (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          bt_state,
  input  logic                          are_we_sending,
  input  logic [7:0]                    stream_select,
  tx_stream_scheduler_if.master         bus,
  output logic [2:0]                    current_stream,
  output logic                          busy,
  output logic [15:0]                   packets_sent
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARB,
    S_POP,
    S_LATCH,
    S_HDR,
    S_HDR_W,
    S_HI,
    S_HI_W,
    S_LO,
    S_LO_W
  } state_t;

  state_t      state;
  state_t      next_state;

  logic        go;
  logic [7:0]  elig;
  logic [2:0]  grant;
  logic        grant_valid;
  logic [15:0] word;
  logic [7:0]  header;
  logic [7:0]  sel_byte;

  logic [7:0]  rd_en_d;
  logic        start_d;
  logic [7:0]  data_d;
  logic        busy_d;
  logic        load_grant;
  logic        pkt_done;

  assign go     = are_we_sending & bt_state;
  assign elig   = stream_select & ~bus.fifo_empty;
  assign header = 8'hA0 | {5'd0, current_stream};

  // Offsets are scanned from farthest to nearest so the nearest eligible stream after
  // current_stream wins; offset 8 wraps back to current_stream itself.
  always_comb begin
    grant       = current_stream;
    grant_valid = 1'b0;
    for (int i = 8; i >= 1; i--) begin
      if (elig[current_stream + 3'(i)]) begin
        grant       = current_stream + 3'(i);
        grant_valid = 1'b1;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of process order.
  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // NOTE: every combinational output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (go) next_state = S_ARB;
      S_ARB: begin
        if (!go)             next_state = S_IDLE;
        else if (grant_valid) next_state = S_POP;
      end
      S_POP:   next_state = S_LATCH;
      S_LATCH: next_state = S_HDR;
      S_HDR:   if (bus.uart_start) next_state = S_HDR_W;
      S_HDR_W: if (bus.uart_ready) next_state = S_HI;
      S_HI:    if (bus.uart_start) next_state = S_HI_W;
      S_HI_W:  if (bus.uart_ready) next_state = S_LO;
      S_LO:    if (bus.uart_start) next_state = S_LO_W;
      S_LO_W:  if (bus.uart_ready) next_state = S_ARB;
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs are registered: this block computes their values for the next cycle.
  // A byte state holds uart_start for its first cycle when the transmitter was already
  // ready on entry; otherwise it waits in place and raises the strobe once ready shows.
  always_comb begin
    rd_en_d    = '0;
    start_d    = 1'b0;
    data_d     = bus.uart_data;
    busy_d     = (next_state != S_IDLE);
    sel_byte   = header;
    load_grant = 1'b0;
    pkt_done   = 1'b0;
    case (state)
      S_ARB: begin
        if (next_state == S_POP) begin
          rd_en_d    = 8'd1 << grant;
          load_grant = 1'b1;
        end
      end
      S_LATCH: begin
        sel_byte = header;
        start_d  = bus.uart_ready;
      end
      S_HDR: begin
        sel_byte = header;
        start_d  = !bus.uart_start && bus.uart_ready;
      end
      S_HDR_W: begin
        sel_byte = word[15:8];
        start_d  = bus.uart_ready;
      end
      S_HI: begin
        sel_byte = word[15:8];
        start_d  = !bus.uart_start && bus.uart_ready;
      end
      S_HI_W: begin
        sel_byte = word[7:0];
        start_d  = bus.uart_ready;
      end
      S_LO: begin
        sel_byte = word[7:0];
        start_d  = !bus.uart_start && bus.uart_ready;
      end
      S_LO_W: pkt_done = bus.uart_ready;
      default: ;
    endcase
    if (start_d) data_d = sel_byte;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      bus.fifo_rd_en <= '0;
      bus.uart_start <= 1'b0;
      bus.uart_data  <= '0;
      current_stream <= 3'd7;
      busy           <= 1'b0;
      packets_sent   <= '0;
    end else begin
      bus.fifo_rd_en <= rd_en_d;
      bus.uart_start <= start_d;
      bus.uart_data  <= data_d;
      busy           <= busy_d;
      if (load_grant) current_stream <= grant;
      if (pkt_done)   packets_sent   <= packets_sent + 16'd1;
    end
  end

  // NOTE: the word register is pure datapath, always written in LATCH before any byte
  // state reads it, so it carries no reset.
  always_ff @(posedge clock) begin
    if (state == S_LATCH) word <= bus.fifo_data[{current_stream, 4'b0000} +: 16];
  end

endmodule

// File: tb/tb_tx_stream_scheduler.sv
// Directed bench for tx_stream_scheduler with a behavioural FIFO bank and a UART
// transmitter that stays busy for 10 cycles after each accepted start.
module tb_tx_stream_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        bt_state;
  logic        are_we_sending;
  logic [7:0]  stream_select;
  logic [2:0]  current_stream;
  logic        busy;
  logic [15:0] packets_sent;

  tx_stream_scheduler_if bus_if ();

  tx_stream_scheduler dut (
    .clock          (clock),
    .reset          (reset),
    .bt_state       (bt_state),
    .are_we_sending (are_we_sending),
    .stream_select  (stream_select),
    .bus            (bus_if),
    .current_stream (current_stream),
    .busy           (busy),
    .packets_sent   (packets_sent)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // FIFO bank: the initial block owns mem/wp, the pop process owns rp/fifo_data.
  logic [15:0] mem [8][16];
  logic [3:0]  wp [8] = '{default: '0};
  logic [3:0]  rp [8] = '{default: '0};

  always_comb begin
    for (int i = 0; i < 8; i++) bus_if.fifo_empty[i] = (wp[i] == rp[i]);
  end

  always @(posedge clock) begin
    for (int i = 0; i < 8; i++) begin
      if (bus_if.fifo_rd_en[i]) begin
        bus_if.fifo_data[16*i +: 16] <= mem[i][rp[i]];
        rp[i] <= rp[i] + 4'd1;
      end
    end
  end

  // Transmitter model plus protocol monitors.
  logic [3:0] ucnt = '0;
  assign bus_if.uart_ready = (ucnt == 4'd0);

  logic [7:0] byte_log [256];
  logic [7:0] rd_log [64];
  int         st_cyc [256];
  int         rd_cyc [64];
  int         nbytes = 0;
  int         nrd = 0;
  int         cyc = 0;
  int         gap_viol = 0;
  int         busy_viol = 0;
  int         hold_viol = 0;
  logic       prev_start = 1'b0;
  logic [7:0] prev_data = '0;
  logic       reset_q = 1'b0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (bus_if.uart_start) begin
      if (ucnt != 4'd0) busy_viol <= busy_viol + 1;
      byte_log[nbytes] <= bus_if.uart_data;
      st_cyc[nbytes]   <= cyc;
      nbytes           <= nbytes + 1;
      ucnt             <= 4'd10;
    end else if (ucnt != 4'd0) begin
      ucnt <= ucnt - 4'd1;
    end
    if (bus_if.fifo_rd_en != 8'd0) begin
      rd_log[nrd] <= bus_if.fifo_rd_en;
      rd_cyc[nrd] <= cyc;
      nrd         <= nrd + 1;
    end
    if (prev_start && bus_if.uart_start) gap_viol <= gap_viol + 1;
    if (reset_q && !bus_if.uart_start && bus_if.uart_data != prev_data) hold_viol <= hold_viol + 1;
    prev_start <= bus_if.uart_start;
    prev_data  <= bus_if.uart_data;
    reset_q    <= reset;
  end

  logic [7:0] exp_rr [18] = '{8'hA0, 8'h01, 8'h02, 8'hA3, 8'h31, 8'h32, 8'hA5, 8'h51, 8'h52,
                              8'hA0, 8'h03, 8'h04, 8'hA3, 8'h33, 8'h34, 8'hA5, 8'h53, 8'h54};
  logic [7:0] exp_rd [6]  = '{8'h01, 8'h08, 8'h20, 8'h01, 8'h08, 8'h20};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int s, input logic [15:0] w);
    mem[s][wp[s]] = w;
    wp[s] = wp[s] + 4'd1;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_rd_en"}, bus_if.fifo_rd_en, 8'h00);
    check({pfx, "_start"}, bus_if.uart_start, 1'b0);
    check({pfx, "_data"}, bus_if.uart_data, 8'h00);
    check({pfx, "_cs"}, current_stream, 3'd7);
    check({pfx, "_busy"}, busy, 1'b0);
    check({pfx, "_packets"}, packets_sent, 16'd0);
  endtask

  int t;
  int bbase;
  int rbase;

  initial begin
    reset          = 1'b0;
    bt_state       = 1'b0;
    are_we_sending = 1'b0;
    stream_select  = 8'h00;
    repeat (5) @(negedge clock);
    check_reset_values("rst");

    // Single stream: stream 2 holds BEEF.
    push(2, 16'hBEEF);
    stream_select  = 8'h04;
    bt_state       = 1'b1;
    are_we_sending = 1'b1;
    reset          = 1'b1;
    t = 0;
    while (packets_sent !== 16'd1 && t < 300) begin @(negedge clock); t++; end
    check("t1_packets", packets_sent, 16'd1);
    check("t1_hdr", byte_log[0], 8'hA2);
    check("t1_hi", byte_log[1], 8'hBE);
    check("t1_lo", byte_log[2], 8'hEF);
    check("t1_latency", st_cyc[0] - rd_cyc[0], 2);
    repeat (20) @(negedge clock);
    check("t1_busy", busy, 1'b1);
    check("t1_cs", current_stream, 3'd2);
    check("t1_rd_count", nrd, 1);
    check("t1_nbytes", nbytes, 3);

    // Round-robin over streams 0, 3, 5 with two words each, from a fresh reset.
    reset         = 1'b0;
    stream_select = 8'h29;
    repeat (2) @(negedge clock);
    check("t2_reset_cs", current_stream, 3'd7);
    push(0, 16'h0102); push(0, 16'h0304);
    push(3, 16'h3132); push(3, 16'h3334);
    push(5, 16'h5152); push(5, 16'h5354);
    bbase = nbytes;
    rbase = nrd;
    reset = 1'b1;
    t = 0;
    while (packets_sent !== 16'd6 && t < 800) begin @(negedge clock); t++; end
    check("t2_packets", packets_sent, 16'd6);
    for (int i = 0; i < 18; i++) check($sformatf("t2_byte%0d", i), byte_log[bbase + i], exp_rr[i]);
    for (int i = 0; i < 6; i++) check($sformatf("t2_grant%0d", i), rd_log[rbase + i], exp_rd[i]);

    // Gating: bt_state drops while the high byte is in flight.
    bbase = nbytes;
    rbase = nrd;
    stream_select = 8'h02;
    push(1, 16'hCAFE);
    push(1, 16'hD00D);
    t = 0;
    while (nbytes != bbase + 2 && t < 200) begin @(negedge clock); t++; end
    bt_state = 1'b0;
    t = 0;
    while (busy !== 1'b0 && t < 100) begin @(negedge clock); t++; end
    repeat (20) @(negedge clock);
    check("t3_busy", busy, 1'b0);
    check("t3_nbytes", nbytes - bbase, 3);
    check("t3_hdr", byte_log[bbase], 8'hA1);
    check("t3_hi", byte_log[bbase + 1], 8'hCA);
    check("t3_lo", byte_log[bbase + 2], 8'hFE);
    check("t3_packets", packets_sent, 16'd7);
    check("t3_rd_count", nrd - rbase, 1);
    bt_state = 1'b1;
    t = 0;
    while (packets_sent !== 16'd8 && t < 300) begin @(negedge clock); t++; end
    check("t3_resume_packets", packets_sent, 16'd8);
    check("t3_resume_grant", rd_log[rbase + 1], 8'h02);
    check("t3_resume_hi", byte_log[bbase + 4], 8'hD0);
    check("t3_resume_lo", byte_log[bbase + 5], 8'h0D);

    // Masking and empty: all selected, only stream 6 non-empty; bit 6 cleared during POP.
    stream_select = 8'hFF;
    repeat (3) @(negedge clock);
    bbase = nbytes;
    rbase = nrd;
    push(6, 16'h6A5C);
    t = 0;
    while (bus_if.fifo_rd_en === 8'h00 && t < 20) begin @(negedge clock); t++; end
    check("t4_rd_en", bus_if.fifo_rd_en, 8'h40);
    stream_select = 8'hBF;
    push(6, 16'h7B7B);
    t = 0;
    while (packets_sent !== 16'd9 && t < 200) begin @(negedge clock); t++; end
    repeat (15) @(negedge clock);
    check("t4_packets", packets_sent, 16'd9);
    check("t4_hdr", byte_log[bbase], 8'hA6);
    check("t4_hi", byte_log[bbase + 1], 8'h6A);
    check("t4_lo", byte_log[bbase + 2], 8'h5C);
    check("t4_rd_count", nrd - rbase, 1);
    check("t4_busy", busy, 1'b1);
    check("t4_cs", current_stream, 3'd6);

    // Reset while the high byte is being launched.
    bbase = nbytes;
    stream_select = 8'h40;
    t = 0;
    while (nbytes != bbase + 1 && t < 50) begin @(negedge clock); t++; end
    t = 0;
    while (bus_if.uart_start !== 1'b1 && t < 50) begin @(negedge clock); t++; end
    check("t5_hi_data", bus_if.uart_data, 8'h7B);
    reset = 1'b0;
    @(negedge clock);
    check_reset_values("t5");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (30) @(negedge clock);
    check("t5_nbytes", nbytes - bbase, 2);
    check("t5_packets", packets_sent, 16'd0);
    check("t5_busy", busy, 1'b1);
    check("t5_cs", current_stream, 3'd7);

    // Counter wrap from a forced preload.
    force dut.packets_sent = 16'hFFFF;
    @(negedge clock);
    release dut.packets_sent;
    @(negedge clock);
    check("t6_preload", packets_sent, 16'hFFFF);
    stream_select = 8'h10;
    push(4, 16'h4444);
    t = 0;
    while (packets_sent === 16'hFFFF && t < 200) begin @(negedge clock); t++; end
    check("t6_wrap", packets_sent, 16'd0);

    check("mon_gap", gap_viol, 0);
    check("mon_start_busy", busy_viol, 0);
    check("mon_data_hold", hold_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
